// File: rtl/rv32i_types.sv
// Shared types for the unified memory-port arbiter: FSM states, latched request, requester IDs.
// No logic here; widths match the arbiter's default ADDR_WIDTH/DATA_WIDTH.
// Backpressure: n/a.
package rv32i_types;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_MASK_W = MEM_DATA_W / 8;

    localparam logic ARB_IMEM = 1'b0;
    localparam logic ARB_DMEM = 1'b1;

    typedef enum logic [1:0] {
        arb_idle_s,
        arb_busy_i_s,
        arb_busy_d_s
    } arb_state_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_MASK_W-1:0] rmask;
        logic [MEM_MASK_W-1:0] wmask;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; grant is combinational from req_i.
// Latency 0; the priority pointer moves to the loser only when accept_i takes the grant.
// Backpressure: a grant that is not accepted leaves the pointer untouched.
module rr_arbiter2
    import rv32i_types::*;
#(
    parameter logic INIT_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic prio_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    // Point at the requester that did not win, so a contending pair alternates.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= INIT_PRIO;
        end else if (accept_i && (gnt_o != 2'b00)) begin
            prio_q <= gnt_o[ARB_IMEM] ? ARB_DMEM : ARB_IMEM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the cache port between fetch and LSQ, one transaction outstanding; ARB_BYPASS_EN drives mem_* in the grant cycle.
// Latency: grant to cache 1 cycle (0 with ARB_BYPASS_EN); response routed combinationally on mem_resp.
// Backpressure: requesters hold their masks until their resp; the loser waits for the next IDLE cycle.
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INIT_PRIO  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic [DATA_WIDTH/8-1:0] imem_rmask,
    input  logic                    imem_flush,
    output logic [DATA_WIDTH-1:0]   imem_rdata,
    output logic                    imem_resp,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr,
    input  logic [DATA_WIDTH/8-1:0] dmem_rmask,
    input  logic [DATA_WIDTH/8-1:0] dmem_wmask,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata,
    input  logic                    dmem_flush,
    output logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic                    dmem_resp,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_rmask,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp,
    output logic                    owner
);

    localparam logic                  INIT_OWNER = (INIT_PRIO != 0) ? ARB_DMEM : ARB_IMEM;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    arb_state_t state_q;
    mem_req_t   req_q;
    logic       squash_q;
    logic       owner_q;

    logic       imem_vld;
    logic       dmem_vld;
    logic [1:0] gnt;
    logic       is_idle;
    mem_req_t   imem_req;
    mem_req_t   dmem_req;
    mem_req_t   idle_req;
    mem_req_t   out_req;
    logic       own_flush;
    logic       squash_d;

    // A flushed requester is invisible to arbitration for that cycle only.
    assign imem_vld = (imem_rmask != '0) && !imem_flush;
    assign dmem_vld = ((dmem_rmask | dmem_wmask) != '0) && !dmem_flush;
    assign is_idle  = (state_q == arb_idle_s);

    rr_arbiter2 #(
        .INIT_PRIO (INIT_OWNER)
    ) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({dmem_vld, imem_vld}),
        .accept_i (is_idle),
        .gnt_o    (gnt)
    );

    always_comb begin
        imem_req       = '0;
        imem_req.addr  = MEM_ADDR_W'(imem_addr & ALIGN_MASK);
        imem_req.rmask = MEM_MASK_W'(imem_rmask);

        // A combined load/store request is issued as the store only.
        dmem_req       = '0;
        dmem_req.addr  = MEM_ADDR_W'(dmem_addr & ALIGN_MASK);
        dmem_req.wmask = MEM_MASK_W'(dmem_wmask);
        dmem_req.wdata = MEM_DATA_W'(dmem_wdata);
        dmem_req.rmask = (dmem_wmask != '0) ? '0 : MEM_MASK_W'(dmem_rmask);
    end

`ifdef ARB_BYPASS_EN
    assign idle_req = gnt[ARB_IMEM] ? imem_req : (gnt[ARB_DMEM] ? dmem_req : '0);
`else
    assign idle_req = '0;
`endif

    assign out_req   = is_idle ? idle_req : req_q;
    assign mem_addr  = ADDR_WIDTH'(out_req.addr);
    assign mem_rmask = (DATA_WIDTH/8)'(out_req.rmask);
    assign mem_wmask = (DATA_WIDTH/8)'(out_req.wmask);
    assign mem_wdata = DATA_WIDTH'(out_req.wdata);
    assign owner     = owner_q;

    // Only reads are squashable; a flush coinciding with mem_resp still squashes it.
    assign own_flush = (state_q == arb_busy_d_s) ? dmem_flush : imem_flush;
    assign squash_d  = squash_q || (own_flush && (req_q.rmask != '0));

    assign imem_resp  = (state_q == arb_busy_i_s) && mem_resp && !squash_d;
    assign dmem_resp  = (state_q == arb_busy_d_s) && mem_resp && !squash_d;
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= arb_idle_s;
            req_q    <= '0;
            squash_q <= 1'b0;
            owner_q  <= INIT_OWNER;
        end else begin
            case (state_q)
                arb_idle_s: begin
                    squash_q <= 1'b0;
                    if (gnt[ARB_IMEM]) begin
                        state_q <= arb_busy_i_s;
                        req_q   <= imem_req;
                        owner_q <= ARB_IMEM;
                    end else if (gnt[ARB_DMEM]) begin
                        state_q <= arb_busy_d_s;
                        req_q   <= dmem_req;
                        owner_q <= ARB_DMEM;
                    end
                end
                arb_busy_i_s, arb_busy_d_s: begin
                    if (mem_resp) begin
                        state_q  <= arb_idle_s;
                        squash_q <= 1'b0;
                    end else begin
                        squash_q <= squash_d;
                    end
                end
                default: begin
                    state_q  <= arb_idle_s;
                    squash_q <= 1'b0;
                end
            endcase
        end
    end

    // The cache must never answer when nothing is outstanding.
    a_no_idle_resp: assert property (@(posedge clk) disable iff (rst) !(is_idle && mem_resp));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, alignment, squash, store commit, reset.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after it.
// Expectations for the grant cycle follow the ARB_BYPASS_EN build option.
module tb_mem_port_arbiter;

`ifdef ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        imem_flush;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_flush;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .INIT_PRIO  (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_flush (imem_flush),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_flush (dmem_flush),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_addr   (mem_addr),
        .mem_rmask  (mem_rmask),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .owner      (owner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        imem_addr = '0; imem_rmask = '0; imem_flush = 1'b0;
        dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0; dmem_flush = 1'b0;
        mem_rdata = '0; mem_resp = 1'b0;

        tick(); tick(); #1;
        chk("rst_rmask", mem_rmask, 4'h0);
        chk("rst_wmask", mem_wmask, 4'h0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_iresp", imem_resp, 1'b0);
        chk("rst_dresp", dmem_resp, 1'b0);

        // imem-only read, response three cycles after the grant
        tick(); rst = 1'b0; imem_addr = 32'h0000_1004; imem_rmask = 4'hF; #1;
        chk("t1_grant_addr", mem_addr, BYP ? 32'h0000_1004 : 32'h0);
        chk("t1_grant_rmask", mem_rmask, BYP ? 4'hF : 4'h0);
        tick(); #1;
        chk("t1_addr", mem_addr, 32'h0000_1004);
        chk("t1_rmask", mem_rmask, 4'hF);
        chk("t1_owner", owner, 1'b0);
        tick(); #1;
        chk("t1_hold_addr", mem_addr, 32'h0000_1004);
        chk("t1_no_early_resp", imem_resp, 1'b0);
        tick(); mem_resp = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        chk("t1_iresp", imem_resp, 1'b1);
        chk("t1_irdata", imem_rdata, 32'hDEAD_BEEF);
        chk("t1_dresp", dmem_resp, 1'b0);
        tick(); mem_resp = 1'b0; imem_rmask = 4'h0; #1;
        chk("t1_iresp_pulse", imem_resp, 1'b0);
        chk("t1_idle_rmask", mem_rmask, 4'h0);

        // simultaneous pair straight after reset: imem first, dmem after the IDLE cycle
        rst = 1'b1;
        tick(); rst = 1'b0;
        imem_addr = 32'h0000_0100; imem_rmask = 4'hF;
        dmem_addr = 32'h0000_0200; dmem_rmask = 4'hF;
        tick(); #1;
        chk("t2_first_owner", owner, 1'b0);
        chk("t2_first_addr", mem_addr, 32'h0000_0100);
        tick(); mem_resp = 1'b1; mem_rdata = 32'h0000_0011; #1;
        chk("t2_iresp", imem_resp, 1'b1);
        chk("t2_dresp_quiet", dmem_resp, 1'b0);
        tick(); mem_resp = 1'b0; imem_rmask = 4'h0; #1;
        chk("t2_gap_rmask", mem_rmask, BYP ? 4'hF : 4'h0);
        tick(); #1;
        chk("t2_second_owner", owner, 1'b1);
        chk("t2_second_addr", mem_addr, 32'h0000_0200);
        tick(); mem_resp = 1'b1; mem_rdata = 32'h0000_0022; #1;
        chk("t2_dresp", dmem_resp, 1'b1);
        chk("t2_drdata", dmem_rdata, 32'h0000_0022);
        chk("t2_iresp_quiet", imem_resp, 1'b0);
        tick(); mem_resp = 1'b0; dmem_rmask = 4'h0;
        imem_addr = 32'h0000_0300; imem_rmask = 4'hF;
        tick(); #1;
        chk("t2_solo_owner", owner, 1'b0);
        tick(); mem_resp = 1'b1; #1;
        tick(); mem_resp = 1'b0; imem_rmask = 4'h0;
        // pointer now favours dmem
        imem_addr = 32'h0000_0400; imem_rmask = 4'hF;
        dmem_addr = 32'h0000_0500; dmem_rmask = 4'hF;
        tick(); #1;
        chk("t2_pair2_owner", owner, 1'b1);
        chk("t2_pair2_addr", mem_addr, 32'h0000_0500);
        tick(); mem_resp = 1'b1; #1;
        chk("t2_pair2_dresp", dmem_resp, 1'b1);
        tick(); mem_resp = 1'b0; dmem_rmask = 4'h0;
        tick(); #1;
        chk("t2_pair2_next_owner", owner, 1'b0);
        chk("t2_pair2_next_addr", mem_addr, 32'h0000_0400);
        tick(); mem_resp = 1'b1; #1;
        chk("t2_pair2_iresp", imem_resp, 1'b1);
        tick(); mem_resp = 1'b0; imem_rmask = 4'h0;

        // unaligned store with a read mask too: write wins, address aligned
        dmem_addr = 32'h0000_2003; dmem_wmask = 4'h8; dmem_rmask = 4'hF; dmem_wdata = 32'hAA00_0000;
        tick(); #1;
        chk("t3_addr", mem_addr, 32'h0000_2000);
        chk("t3_wmask", mem_wmask, 4'h8);
        chk("t3_wdata", mem_wdata, 32'hAA00_0000);
        chk("t3_rmask", mem_rmask, 4'h0);
        tick(); #1;
        chk("t3_hold_addr", mem_addr, 32'h0000_2000);
        chk("t3_hold_wmask", mem_wmask, 4'h8);
        tick(); mem_resp = 1'b1; #1;
        chk("t3_dresp", dmem_resp, 1'b1);
        tick(); mem_resp = 1'b0; dmem_wmask = 4'h0; dmem_rmask = 4'h0;

        // flushed imem in IDLE loses even though the pointer favours it
        imem_addr = 32'h0000_0600; imem_rmask = 4'hF; imem_flush = 1'b1;
        dmem_addr = 32'h0000_0700; dmem_rmask = 4'hF;
        tick(); imem_flush = 1'b0; imem_rmask = 4'h0; #1;
        chk("t4_flushidle_owner", owner, 1'b1);
        chk("t4_flushidle_addr", mem_addr, 32'h0000_0700);
        // dmem load squashed by a mid-wait flush
        tick(); dmem_flush = 1'b1; dmem_rmask = 4'h0; #1;
        tick(); dmem_flush = 1'b0; #1;
        tick(); mem_resp = 1'b1; mem_rdata = 32'h0000_0077; #1;
        chk("t4_squashed_dresp", dmem_resp, 1'b0);
        chk("t4_squashed_iresp", imem_resp, 1'b0);
        tick(); mem_resp = 1'b0; imem_addr = 32'h0000_0800; imem_rmask = 4'hF;
        tick(); #1;
        chk("t4_next_owner", owner, 1'b0);
        chk("t4_next_addr", mem_addr, 32'h0000_0800);
        tick(); mem_resp = 1'b1; mem_rdata = 32'h0000_0088; #1;
        chk("t4_next_iresp", imem_resp, 1'b1);
        chk("t4_next_irdata", imem_rdata, 32'h0000_0088);
        tick(); mem_resp = 1'b0; imem_rmask = 4'h0;
        // flush arriving with mem_resp squashes too
        tick(); imem_addr = 32'h0000_0900; imem_rmask = 4'hF;
        tick(); #1;
        chk("t4b_owner", owner, 1'b0);
        tick(); mem_resp = 1'b1; imem_flush = 1'b1; #1;
        chk("t4b_flush_at_resp", imem_resp, 1'b0);
        tick(); mem_resp = 1'b0; imem_flush = 1'b0; imem_rmask = 4'h0;

        // store is committed despite flush
        dmem_addr = 32'h0000_0A04; dmem_wmask = 4'hF; dmem_wdata = 32'h1234_5678;
        tick(); #1;
        chk("t5_owner", owner, 1'b1);
        chk("t5_wmask", mem_wmask, 4'hF);
        tick(); dmem_flush = 1'b1; #1;
        tick(); mem_resp = 1'b1; #1;
        chk("t5_store_resp", dmem_resp, 1'b1);
        tick(); mem_resp = 1'b0; dmem_flush = 1'b0; dmem_wmask = 4'h0;

        // reset while a dmem load is outstanding
        dmem_addr = 32'h0000_0B00; dmem_rmask = 4'hF;
        tick(); #1;
        chk("t6_busy_owner", owner, 1'b1);
        chk("t6_busy_rmask", mem_rmask, 4'hF);
        tick(); rst = 1'b1;
        tick(); #1;
        chk("t6_rst_rmask", mem_rmask, 4'h0);
        chk("t6_rst_wmask", mem_wmask, 4'h0);
        chk("t6_rst_owner", owner, 1'b0);
        chk("t6_rst_dresp", dmem_resp, 1'b0);
        rst = 1'b0; dmem_rmask = 4'h0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
